// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches ROM instructions, issues ops to a registered ALU and writes back results
module alu_sequencer #(
  parameter int         ALU_LAT  = 2,
  parameter logic [4:0] IDLE_SEL = 5'b11111
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  output logic [7:0]  oPC,
  input  logic [15:0] iInstr,
  output logic [7:0]  oA,
  output logic [7:0]  oB,
  output logic [4:0]  oALU_Sel,
  input  logic [7:0]  iRESALU,
  input  logic [4:0]  iBanderas,
  output logic [4:0]  oFlags,
  output logic [7:0]  oOut,
  output logic        oOutValid,
  output logic        oBusy,
  output logic        oHalted
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;
  localparam logic [4:0] OP_LAST_ALU = 5'd16;
  localparam logic [4:0] OP_LDI  = 5'd17;
  localparam logic [4:0] OP_JMP  = 5'd18;
  localparam logic [4:0] OP_BRZ  = 5'd19;
  localparam logic [4:0] OP_BRC  = 5'd20;
  localparam logic [4:0] OP_OUT  = 5'd21;
  localparam logic [4:0] OP_HALT = 5'd31;
  logic [2:0] state;
  logic [7:0] pc;
  logic [7:0] r [4];
  logic [1:0] wb_rd;
  logic [7:0] cnt;
  logic [4:0] op;
  logic [1:0] rd, ra, rb;
  logic [7:0] imm;
  logic       take;
  assign op   = iInstr[15:11];
  assign rd   = iInstr[10:9];
  assign ra   = iInstr[8:7];
  assign rb   = iInstr[6:5];
  assign imm  = iInstr[7:0];
  assign take = op == OP_JMP || (op == OP_BRZ && oFlags[0]) || (op == OP_BRC && oFlags[2]);
  assign oPC     = pc;
  assign oBusy   = state != S_IDLE && state != S_HALTED;
  assign oHalted = state == S_HALTED;
  // Fetch/decode/execute control, register file and ALU operand/writeback handling
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      r         <= '{default: 8'h00};
      wb_rd     <= '0;
      cnt       <= '0;
      oA        <= '0;
      oB        <= '0;
      oALU_Sel  <= IDLE_SEL;
      oFlags    <= '0;
      oOut      <= '0;
      oOutValid <= 1'b0;
    end else begin
      oOutValid <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: if (iStart) begin
          pc    <= '0;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          wb_rd <= rd;
          if (op <= OP_LAST_ALU) begin
            oA       <= r[ra];
            oB       <= r[rb];
            oALU_Sel <= op;
            cnt      <= '0;
            state    <= S_EXEC;
          end else if (op == OP_HALT) begin
            state <= S_HALTED;
          end else begin
            if (op == OP_LDI) r[rd] <= imm;
            if (op == OP_OUT) begin
              oOut      <= r[ra];
              oOutValid <= 1'b1;
            end
            pc    <= take ? imm : pc + 8'd1;
            state <= S_FETCH;
          end
        end
        S_EXEC: begin
          cnt   <= cnt + 8'd1;
          state <= cnt == 8'(ALU_LAT - 1) ? S_WB : S_EXEC;
        end
        S_WB: begin
          r[wb_rd] <= iRESALU;
          oFlags   <= iBanderas;
          oALU_Sel <= IDLE_SEL;
          pc       <= pc + 8'd1;
          state    <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction sequencer that drives the 8-bit registered ALU (5-bit select, result and 5-bit flags registered inside the ALU) from the issuing side.
- Fetches 16-bit instructions from a synchronous program ROM and holds four 8-bit working registers.
- Issues ALU operations, waits out the ALU register latency, and writes back the result and flags.
- Executes load-immediate, jump, flag branches, output and halt directly.

Parameters:
- ALU_LAT, 2, cycles the ALU inputs are held before the result and flags are sampled. Must be >=2 because the zero, sign and parity flags lag the result by one cycle.
- IDLE_SEL, 5'b11111, select driven when no ALU op is in flight. This is an unused code, so the ALU holds its result.

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iStart  in  1  start pulse; honoured only in IDLE or HALTED
- oPC  out  8  program ROM address
- iInstr  in  16  ROM data, valid one cycle after oPC
- oA  out  8  ALU operand A
- oB  out  8  ALU operand B
- oALU_Sel  out  5  ALU operation select
- iRESALU  in  8  ALU registered result
- iBanderas  in  5  ALU flags: [0] Z, [1] S, [2] C, [3] V, [4] P
- oFlags  out  5  flags latched at last ALU writeback
- oOut  out  8  output port data
- oOutValid  out  1  one-cycle strobe for oOut
- oBusy  out  1  high outside IDLE/HALTED
- oHalted  out  1  high in HALTED

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - state=IDLE; PC, R0-R3, oA, oB, oFlags, oOut all 0.
  - oOutValid=0, oBusy=0, oHalted=0, oALU_Sel=IDLE_SEL.
- Encoding: op=[15:11], rd=[10:9], ra=[8:7], rb=[6:5], imm8=[7:0].
- op 00000-10000, ALU op: oA=R[ra], oB=R[rb], oALU_Sel=op.
- op 10001, LDI: R[rd]=imm8.
- op 10010, JMP: PC=imm8.
- op 10011, BRZ: if oFlags[0], PC=imm8, else PC+1.
- op 10100, BRC: as BRZ, using oFlags[2].
- op 10101, OUT: oOut=R[ra]; oOutValid=1 for one cycle.
- op 11111, HALT.
- op 10110-11110: NOP, PC+1.
- State sequence:
  - IDLE: wait for iStart; on iStart, PC=0 -> FETCH.
  - FETCH: oPC=PC (1 cycle) -> DECODE.
  - DECODE: latch iInstr.
    - ALU op: load oA/oB/oALU_Sel, clear wait counter -> EXEC.
    - Non-ALU op: complete in this cycle, update PC -> FETCH.
    - HALT -> HALTED.
  - EXEC: hold oA/oB/oALU_Sel stable; count ALU_LAT cycles -> WB.
  - WB: R[rd]=iRESALU, oFlags=iBanderas, oALU_Sel=IDLE_SEL, PC+1 -> FETCH.
  - HALTED: oHalted=1, PC frozen; iStart -> PC=0, FETCH.
- Cycle cost: ALU instruction = 2+ALU_LAT+1 cycles (5 at default); non-ALU instruction = 2 cycles.
- Register and flag retention:
  - R0-R3 and oFlags are retained across HALT/restart; only reset clears them.
  - Branches test flags from the most recent ALU writeback only; LDI/OUT do not alter flags.
- PC arithmetic: 8-bit, wraps 0xFF -> 0x00 with no flag.
- Register hazards: writeback to R[rd] occurs before the next FETCH, so there are none; ra=rd is legal.
- Boundary cases:
  - iStart while oBusy: ignored.
  - iStart held high continuously: one start per IDLE/HALTED entry.
  - Division by zero and similar ALU corner cases: the result and flags are stored as returned; the sequencer does no special handling.
- oOutValid is a registered pulse asserted the cycle after the OUT DECODE cycle; oOut holds its value until the next OUT.

Test Plan:
- Reset: assert iRst_n=0 mid-EXEC -> in the same cycle oBusy=0 and oALU_Sel=11111; R0-R3, oPC and oFlags read 0.
- Add: LDI R0,0x0F; LDI R1,0x01; ADD R2=R0+R1; OUT R2; HALT -> oOut=0x10 with a one-cycle oOutValid, oFlags[0]=0, oHalted=1 after 13 cycles from iStart.
- Zero branch: LDI R0,5; LDI R1,5; SUB R3=R0-R1; BRZ 0x20 -> R3=0x00, oFlags[0]=1, next oPC=0x20; repeat with R1=4 -> oPC advances to 0x04.
- Carry: LDI R0,0xFF; LDI R1,0x01; ADD; BRC 0x30 -> R2=0x00, oFlags[2]=1, oPC=0x30.
- Operand hold: during EXEC of a MUL (00000) with 0x03*0x04 -> oA/oB/oALU_Sel stable for 2 cycles; WB stores 0x0C; the cycle after WB, oALU_Sel=11111.
- Control: iStart pulsed while busy -> no PC reset; JMP 0xFF then NOP -> oPC wraps to 0x00; iStart in HALTED -> restart at PC 0 with registers retained.
